// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences FETCH..WRITEBACK, drives datapath mux selects
// and strobes, waits on mem_ready in memory states with a watchdog timeout.
module controle_multiciclo #(
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       erro_opcode,
  output logic       erro_timeout,
  output logic [3:0] estado
);

  localparam int CW = $clog2(TIMEOUT_CICLOS);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_wait;
  logic          timeout;
  logic          bad_op;

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                    (state_q == S_MEM_WRITE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    bad_op  = 1'b0;

    // Watchdog: mem_ready on the final cycle still counts as normal completion.
    if (mem_wait && !mem_ready) begin
      if (cnt_q == CW'(TIMEOUT_CICLOS - 1)) timeout = 1'b1;
      else                                  cnt_d   = cnt_q + 1'b1;
    end

    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase

    if (timeout) state_d = S_FETCH;

    // Entering (or re-entering) a waiting state restarts the watchdog.
    if (((state_d == S_FETCH) || (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE)) &&
        ((state_d != state_q) || timeout))
      cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode per state; only FETCH strobes and error pulses look at inputs.
  always_comb begin
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    erro_opcode   = 1'b0;
    erro_timeout  = 1'b0;
    estado        = 4'd0;
    if (!reset) begin
      estado       = state_q;
      erro_opcode  = bad_op;
      erro_timeout = timeout;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          ior_d    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          ior_d     = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB:   reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed self-checking bench for controle_multiciclo: instruction sequences,
// fetch stall, bad opcode, watchdog boundary and mid-instruction reset.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ior_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, erro_opcode, erro_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] estado;
  logic [18:0] ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(.TIMEOUT_CICLOS(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .erro_opcode(erro_opcode),
    .erro_timeout(erro_timeout), .estado(estado)
  );

  assign ctrl = {ior_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond, alu_src_a,
                 alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, reg_write,
                 erro_opcode, erro_timeout};

  // Expected control word built from hand-written per-field values.
  function automatic logic [18:0] cv(input logic ior, mr, mw, ir, pw, pwc, asa,
                                     input logic [1:0] asb, aop, psrc,
                                     input logic rd, m2r, rw, eo, et);
    return {ior, mr, mw, ir, pw, pwc, asa, asb, aop, psrc, rd, m2r, rw, eo, et};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st, input logic [18:0] cw);
    check({tag, "_estado"}, 32'(estado), 32'(st));
    check({tag, "_ctrl"}, 32'(ctrl), 32'(cw));
  endtask

  logic [18:0] fetch_idle, fetch_go, decode_cw;

  initial begin
    fetch_idle = cv(0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0,0,0);
    fetch_go   = cv(0,1,0,1,1,0,0,2'b01,2'b00,2'b00,0,0,0,0,0);
    decode_cw  = cv(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0,0,0);

    reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
    #1;
    expect_state("reset_hold", 4'd0, 19'd0);
    tick(); tick();
    reset = 1'b0; mem_ready = 1'b0; #1;
    expect_state("post_reset", 4'd0, fetch_idle);

    // Fetch stall: 3 cycles without mem_ready, strobes on the 4th.
    for (int i = 0; i < 3; i++) begin
      expect_state("fetch_stall", 4'd0, fetch_idle);
      tick();
    end
    mem_ready = 1'b1; opcode = 6'h23; #1;
    expect_state("fetch_go", 4'd0, fetch_go);

    // lw: 0,1,2,3,4,0
    tick(); expect_state("lw_decode", 4'd1, decode_cw);
    tick(); expect_state("lw_addr", 4'd2, cv(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0,0));
    tick(); expect_state("lw_read", 4'd3, cv(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0));
    tick(); expect_state("lw_wb", 4'd4, cv(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,1,0,0));
    tick(); expect_state("lw_done", 4'd0, fetch_go);

    // beq: 0,1,8,0
    opcode = 6'h04;
    tick(); expect_state("beq_decode", 4'd1, decode_cw);
    tick(); expect_state("beq_branch", 4'd8, cv(0,0,0,0,0,1,1,2'b00,2'b01,2'b01,0,0,0,0,0));
    tick(); check("beq_done_estado", 32'(estado), 32'd0);

    // unsupported opcode: single-cycle pulse in DECODE
    opcode = 6'h3F;
    tick(); expect_state("bad_decode", 4'd1, cv(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0,1,0));
    tick(); expect_state("bad_back", 4'd0, fetch_go);

    // R-type: 0,1,6,7,0
    opcode = 6'h00;
    tick(); expect_state("r_decode", 4'd1, decode_cw);
    tick(); expect_state("r_exec", 4'd6, cv(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0,0,0));
    tick(); expect_state("r_wb", 4'd7, cv(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,1,0,0));
    tick(); check("r_done_estado", 32'(estado), 32'd0);

    // j: 0,1,9,0
    opcode = 6'h02;
    tick(); expect_state("j_decode", 4'd1, decode_cw);
    tick(); expect_state("j_jump", 4'd9, cv(0,0,0,0,1,0,0,2'b00,2'b00,2'b10,0,0,0,0,0));
    tick(); check("j_done_estado", 32'(estado), 32'd0);

    // addi: 0,1,10,11,0
    opcode = 6'h08;
    tick(); expect_state("addi_decode", 4'd1, decode_cw);
    tick(); expect_state("addi_ex", 4'd10, cv(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0,0));
    tick(); expect_state("addi_wb", 4'd11, cv(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1,0,0));
    tick(); check("addi_done_estado", 32'(estado), 32'd0);

    // sw with memory never ready: timeout on 16th cycle in MEM_WRITE
    opcode = 6'h2B;
    tick(); tick(); check("sw_addr_estado", 32'(estado), 32'd2);
    tick(); mem_ready = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      expect_state("sw_wait", 4'd5, cv(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0));
      tick();
    end
    check("sw_to_estado", 32'(estado), 32'd5);
    check("sw_to_pulse", 32'(erro_timeout), 32'd1);
    tick(); expect_state("sw_to_back", 4'd0, fetch_idle);

    // sw with mem_ready arriving on the last allowed cycle: normal completion
    mem_ready = 1'b1; #1;
    tick(); tick();
    tick(); mem_ready = 1'b0; #1;
    check("sw_late_enter", 32'(estado), 32'd5);
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1; #1;
    expect_state("sw_late_ready", 4'd5, cv(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0,0));
    tick(); expect_state("sw_late_done", 4'd0, fetch_go);

    // lw aborted by reset while waiting in MEM_READ
    opcode = 6'h23;
    tick(); tick();
    tick(); mem_ready = 1'b0; #1;
    check("abort_in_read", 32'(estado), 32'd3);
    tick();
    reset = 1'b1; mem_ready = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      expect_state("abort_reset", 4'd0, 19'd0);
      tick();
    end
    reset = 1'b0; mem_ready = 1'b0; #1;
    expect_state("abort_release", 4'd0, fetch_idle);
    tick();
    check("abort_stay_fetch", 32'(estado), 32'd0);
    check("abort_no_regwrite", 32'(reg_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
